flat_mem_window_reader: RTL and testbench

// Read-side master for flatMem: scans the stored 1-bit image in raster order (y outer, x inner).
// For every pixel it fetches the 3x3 neighbourhood through flatMem's x/y read port.
// It presents each window to the median stage over a valid/ready handshake.

---
 rtl/flat_mem_window_reader_if.sv | 29 ++
 rtl/flat_mem_window_reader.sv | 212 +++++++++++++++++++++
 tb/tb_flat_mem_window_reader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flat_mem_window_reader_if.sv
// Control strobes, frame-store read port and window stream of the window reader.
interface flat_mem_window_reader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] memXAddress;
  logic [ADDR_W-1:0] memYAddress;
  logic              memWrite;
  logic              memDataIn;
  logic [8:0]        windowOut;
  logic [ADDR_W-1:0] windowX;
  logic [ADDR_W-1:0] windowY;
  logic              windowValid;
  logic              windowReady;

  modport master (
    input  start, memDataIn, windowReady,
    output busy, done, memXAddress, memYAddress, memWrite,
           windowOut, windowX, windowY, windowValid
  );

  modport slave (
    output start, memDataIn, windowReady,
    input  busy, done, memXAddress, memYAddress, memWrite,
           windowOut, windowX, windowY, windowValid
  );
endinterface

// File: rtl/flat_mem_window_reader.sv
// Raster-scans the frame store and streams a zero-padded 3x3 window per pixel.
module flat_mem_window_reader #(
  parameter int unsigned IMWIDTH    = 240,
  parameter int unsigned IMHEIGHT   = 180,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  flat_mem_window_reader_if.master bus
);
  localparam int unsigned TAP_W = 4;
  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] X_LAST     = ADDR_W'(IMWIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST     = ADDR_W'(IMHEIGHT - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST   = TAP_W'(8);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_x;
  logic [ADDR_W-1:0] cur_y;
  logic [TAP_W-1:0]  tap;
  logic [CNT_W-1:0]  drain_cnt;
  logic              addr_oob;
  logic [ADDR_W-1:0] addr_x;
  logic [ADDR_W-1:0] addr_y;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [8:0]        window_q;
  logic [ADDR_W-1:0] win_x_q;
  logic [ADDR_W-1:0] win_y_q;

  logic [RD_LATENCY-1:0]            pipe_valid;
  logic [RD_LATENCY-1:0][TAP_W-1:0] pipe_tap;
  logic [RD_LATENCY-1:0]            pipe_oob;

  logic              last_pixel_c;
  logic [ADDR_W-1:0] next_x_c;
  logic [ADDR_W-1:0] next_y_c;
  logic [ADDR_W-1:0] sel_x_c;
  logic [ADDR_W-1:0] sel_y_c;
  logic [TAP_W-1:0]  sel_tap_c;
  logic [3:0]        rc_c;
  logic [ADDR_W-1:0] tap_x_c;
  logic [ADDR_W-1:0] tap_y_c;
  logic              tap_oob_c;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.memXAddress = addr_x;
  assign bus.memYAddress = addr_y;
  assign bus.memWrite    = 1'b0;
  assign bus.windowOut   = window_q;
  assign bus.windowX     = win_x_q;
  assign bus.windowY     = win_y_q;
  assign bus.windowValid = valid_q;

  // Raster successor of the current centre pixel.
  always_comb begin
    last_pixel_c = (cur_x == X_LAST) && (cur_y == Y_LAST);
    next_x_c     = cur_x + ADDR_W'(1);
    next_y_c     = cur_y;
    if (cur_x == X_LAST) begin
      next_x_c = '0;
      next_y_c = cur_y + ADDR_W'(1);
    end
  end

  // Pick the pixel/tap whose address is loaded at the next edge.
  always_comb begin
    sel_x_c   = cur_x;
    sel_y_c   = cur_y;
    sel_tap_c = tap + TAP_W'(1);
    if (state == IDLE) begin
      sel_x_c   = '0;
      sel_y_c   = '0;
      sel_tap_c = '0;
    end else if (state == OUT) begin
      sel_x_c   = next_x_c;
      sel_y_c   = next_y_c;
      sel_tap_c = '0;
    end
  end

  // Tap -> {row, col} offset, then clamp into the image and flag padding taps.
  always_comb begin
    rc_c = 4'b0101;
    case (sel_tap_c)
      4'd0:    rc_c = 4'b0000;
      4'd1:    rc_c = 4'b0001;
      4'd2:    rc_c = 4'b0010;
      4'd3:    rc_c = 4'b0100;
      4'd5:    rc_c = 4'b0110;
      4'd6:    rc_c = 4'b1000;
      4'd7:    rc_c = 4'b1001;
      4'd8:    rc_c = 4'b1010;
      default: rc_c = 4'b0101;
    endcase
    tap_x_c   = sel_x_c;
    tap_y_c   = sel_y_c;
    tap_oob_c = 1'b0;
    case (rc_c[1:0])
      2'd0: if (sel_x_c == '0) tap_oob_c = 1'b1;
            else tap_x_c = sel_x_c - ADDR_W'(1);
      2'd2: if (sel_x_c == X_LAST) tap_oob_c = 1'b1;
            else tap_x_c = sel_x_c + ADDR_W'(1);
      default: ;
    endcase
    case (rc_c[3:2])
      2'd0: if (sel_y_c == '0) tap_oob_c = 1'b1;
            else tap_y_c = sel_y_c - ADDR_W'(1);
      2'd2: if (sel_y_c == Y_LAST) tap_oob_c = 1'b1;
            else tap_y_c = sel_y_c + ADDR_W'(1);
      default: ;
    endcase
  end

  // Scan FSM, read-tag pipeline and window assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      tap        <= '0;
      drain_cnt  <= '0;
      addr_oob   <= 1'b0;
      addr_x     <= '0;
      addr_y     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      window_q   <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      pipe_valid <= '0;
      pipe_tap   <= '0;
      pipe_oob   <= '0;
    end else begin
      done_q <= 1'b0;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tap[i]   <= pipe_tap[i-1];
        pipe_oob[i]   <= pipe_oob[i-1];
      end
      pipe_valid[0] <= (state == FETCH);
      pipe_tap[0]   <= tap;
      pipe_oob[0]   <= addr_oob;
      if (pipe_valid[RD_LATENCY-1]) begin
        window_q[pipe_tap[RD_LATENCY-1]] <= bus.memDataIn & ~pipe_oob[RD_LATENCY-1];
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FETCH;
            busy_q   <= 1'b1;
            cur_x    <= '0;
            cur_y    <= '0;
            tap      <= '0;
            window_q <= '0;
            addr_x   <= tap_x_c;
            addr_y   <= tap_y_c;
            addr_oob <= tap_oob_c;
          end
        end
        FETCH: begin
          if (tap == TAP_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            tap      <= sel_tap_c;
            addr_x   <= tap_x_c;
            addr_y   <= tap_y_c;
            addr_oob <= tap_oob_c;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state   <= OUT;
            valid_q <= 1'b1;
            win_x_q <= cur_x;
            win_y_q <= cur_y;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (bus.windowReady) begin
            valid_q <= 1'b0;
            if (last_pixel_c) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state    <= FETCH;
              cur_x    <= next_x_c;
              cur_y    <= next_y_c;
              tap      <= '0;
              window_q <= '0;
              addr_x   <= tap_x_c;
              addr_y   <= tap_y_c;
              addr_oob <= tap_oob_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flat_mem_window_reader.sv
// Directed bench for flat_mem_window_reader on a reduced 16x24 frame, latency 1 and 3.
module tb_flat_mem_window_reader;
  localparam int unsigned W     = 16;
  localparam int unsigned H     = 24;
  localparam int unsigned AW    = 8;
  localparam int          NPIX  = W * H;
  localparam int          LIMIT = 8000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flat_mem_window_reader_if #(.ADDR_W(AW)) ifa ();
  flat_mem_window_reader_if #(.ADDR_W(AW)) ifb ();

  flat_mem_window_reader #(.IMWIDTH(W), .IMHEIGHT(H), .ADDR_W(AW), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  flat_mem_window_reader #(.IMWIDTH(W), .IMHEIGHT(H), .ADDR_W(AW), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  logic       img [0:511];
  logic [8:0] got [0:511];
  logic       b_d1, b_d2;
  int         n_cmp = 0;
  int         n_fail = 0;

  // Frame store models: one-cycle and three-cycle read latency.
  always_ff @(posedge clk) ifa.memDataIn <= img[{ifa.memYAddress[4:0], ifa.memXAddress[3:0]}];
  always_ff @(posedge clk) begin
    b_d1 <= img[{ifb.memYAddress[4:0], ifb.memXAddress[3:0]}];
    b_d2 <= b_d1;
    ifb.memDataIn <= b_d2;
  end

  task automatic fill_img(input logic v);
    for (int i = 0; i < 512; i++) img[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one frame, records accepted windows; cycles = edges from start edge to done.
  task automatic run_frame(input bit use_b, input int restart_at,
                           output int cycles, output int nwin, output bit mw_bad);
    int  n;
    bit  fin;
    logic v, r, d;
    logic [8:0] wo;
    logic [AW-1:0] wx, wy;
    n = 0; nwin = 0; mw_bad = 1'b0; fin = 1'b0;
    for (int i = 0; i < 512; i++) got[i] = 9'h1EE;
    @(negedge clk);
    if (use_b) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    while (!fin && n < LIMIT) begin
      v  = use_b ? ifb.windowValid : ifa.windowValid;
      r  = use_b ? ifb.windowReady : ifa.windowReady;
      wo = use_b ? ifb.windowOut : ifa.windowOut;
      wx = use_b ? ifb.windowX : ifa.windowX;
      wy = use_b ? ifb.windowY : ifa.windowY;
      if ((use_b ? ifb.memWrite : ifa.memWrite) !== 1'b0) mw_bad = 1'b1;
      if (v && r) begin
        got[{wy[4:0], wx[3:0]}] = wo;
        nwin++;
      end
      if (use_b) ifb.start = (n == restart_at); else ifa.start = (n == restart_at);
      @(posedge clk);
      n++;
      @(negedge clk);
      d = use_b ? ifb.done : ifa.done;
      if (d === 1'b1) fin = 1'b1;
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    cycles = n;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ifa.busy, ifa.done, ifa.windowValid, ifa.memWrite} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {ifa.busy, ifa.done, ifa.windowValid, ifa.memWrite});
    end
    n_cmp++;
    if ({ifa.windowOut, ifa.windowX, ifa.windowY} !== 25'b0) begin
      n_fail++; $display("FAIL reset_window: got %h required 0", {ifa.windowOut, ifa.windowX, ifa.windowY});
    end
    n_cmp++;
    if ({ifa.memXAddress, ifa.memYAddress} !== 16'b0) begin
      n_fail++; $display("FAIL reset_addr: got %h required 0", {ifa.memXAddress, ifa.memYAddress});
    end
    reset = 1'b0;
  endtask

  task automatic test_all_ones(input bit use_b, input int exp_cycles);
    int cyc, nw;
    bit mw;
    fill_img(1'b1);
    run_frame(use_b, -1, cyc, nw, mw);
    n_cmp++;
    if (cyc !== exp_cycles) begin n_fail++; $display("FAIL ones_cycles(b=%0d): got %0d required %0d", use_b, cyc, exp_cycles); end
    n_cmp++;
    if (nw !== NPIX) begin n_fail++; $display("FAIL ones_nwin(b=%0d): got %0d required %0d", use_b, nw, NPIX); end
    n_cmp++;
    if (got[0] !== 9'h1B0) begin n_fail++; $display("FAIL ones_0_0(b=%0d): got %h required 1b0", use_b, got[0]); end
    n_cmp++;
    if (got[17] !== 9'h1FF) begin n_fail++; $display("FAIL ones_1_1(b=%0d): got %h required 1ff", use_b, got[17]); end
    n_cmp++;
    if (got[15] !== 9'h0D8) begin n_fail++; $display("FAIL ones_15_0(b=%0d): got %h required 0d8", use_b, got[15]); end
    n_cmp++;
    if (got[383] !== 9'h01B) begin n_fail++; $display("FAIL ones_15_23(b=%0d): got %h required 01b", use_b, got[383]); end
    n_cmp++;
    if (got[368] !== 9'h036) begin n_fail++; $display("FAIL ones_0_23(b=%0d): got %h required 036", use_b, got[368]); end
  endtask

  task automatic test_lone_pixel(input bit use_b, input int exp_cycles);
    int cyc, nw, nz, stray;
    bit mw;
    fill_img(1'b0);
    img[20*16+10] = 1'b1;
    run_frame(use_b, -1, cyc, nw, mw);
    nz = 0; stray = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (got[yy*16+xx] !== 9'h000) begin
          nz++;
          if (xx < 9 || xx > 11 || yy < 19 || yy > 21) stray++;
        end
    n_cmp++;
    if (cyc !== exp_cycles) begin n_fail++; $display("FAIL lone_cycles(b=%0d): got %0d required %0d", use_b, cyc, exp_cycles); end
    n_cmp++;
    if (nz !== 9) begin n_fail++; $display("FAIL lone_nonzero(b=%0d): got %0d required 9", use_b, nz); end
    n_cmp++;
    if (stray !== 0) begin n_fail++; $display("FAIL lone_stray(b=%0d): got %0d required 0", use_b, stray); end
    n_cmp++;
    if (got[20*16+10] !== 9'h010) begin n_fail++; $display("FAIL lone_10_20(b=%0d): got %h required 010", use_b, got[20*16+10]); end
    n_cmp++;
    if (got[21*16+11] !== 9'h001) begin n_fail++; $display("FAIL lone_11_21(b=%0d): got %h required 001", use_b, got[21*16+11]); end
    n_cmp++;
    if (got[19*16+9] !== 9'h100) begin n_fail++; $display("FAIL lone_9_19(b=%0d): got %h required 100", use_b, got[19*16+9]); end
  endtask

  task automatic test_backpressure();
    int k;
    fill_img(1'b1);
    ifa.windowReady = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    k = 0;
    while (ifa.windowValid !== 1'b1 && k < 50) begin
      @(posedge clk); k++; @(negedge clk);
    end
    n_cmp++;
    if (k !== 10) begin n_fail++; $display("FAIL bp_first_latency: got %0d required 10", k); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({ifa.windowValid, ifa.windowOut, ifa.windowX, ifa.windowY, ifa.memXAddress, ifa.memYAddress}
          !== {1'b1, 9'h1B0, 8'd0, 8'd0, 8'd1, 8'd1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b w=%h x=%0d y=%0d ax=%0d ay=%0d required v=1 w=1b0 x=0 y=0 ax=1 ay=1",
                 c, ifa.windowValid, ifa.windowOut, ifa.windowX, ifa.windowY, ifa.memXAddress, ifa.memYAddress);
      end
      @(negedge clk);
    end
    ifa.windowReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ifa.windowValid, ifa.busy, ifa.memXAddress, ifa.memYAddress} !== {1'b0, 1'b1, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL bp_accept: got v=%b busy=%b ax=%0d ay=%0d required v=0 busy=1 ax=0 ay=0",
                         ifa.windowValid, ifa.busy, ifa.memXAddress, ifa.memYAddress);
    end
    @(negedge clk);
    n_cmp++;
    if ({ifa.memXAddress, ifa.memYAddress} !== {8'd1, 8'd0}) begin
      n_fail++; $display("FAIL bp_next_tap1: got ax=%0d ay=%0d required ax=1 ay=0", ifa.memXAddress, ifa.memYAddress);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_scan();
    int k;
    fill_img(1'b1);
    ifa.windowReady = 1'b1;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    k = 0;
    while (!(ifa.windowValid === 1'b1 && ifa.windowX == 8'd5 && ifa.windowY == 8'd3) && k < 2000) begin
      @(posedge clk); k++; @(negedge clk);
    end
    n_cmp++;
    if (k >= 2000) begin n_fail++; $display("FAIL rst_mid_reach: got timeout %0d required centre (5,3)", k); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ifa.busy, ifa.done, ifa.windowValid, ifa.windowOut, ifa.windowX, ifa.windowY,
         ifa.memXAddress, ifa.memYAddress, ifa.memWrite} !== 45'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got busy=%b v=%b w=%h x=%0d y=%0d ax=%0d ay=%0d required all 0",
                         ifa.busy, ifa.windowValid, ifa.windowOut, ifa.windowX, ifa.windowY,
                         ifa.memXAddress, ifa.memYAddress);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    k = 0;
    while (ifa.windowValid !== 1'b1 && k < 50) begin
      @(posedge clk); k++; @(negedge clk);
    end
    n_cmp++;
    if ({ifa.windowOut, ifa.windowX, ifa.windowY} !== {9'h1B0, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL rst_rescan_first: got w=%h x=%0d y=%0d required w=1b0 x=0 y=0",
                         ifa.windowOut, ifa.windowX, ifa.windowY);
    end
    do_reset();
  endtask

  task automatic test_done_and_restart();
    int cyc, nw, extra;
    bit mw;
    fill_img(1'b0);
    img[5*16+7] = 1'b1;
    ifa.windowReady = 1'b1;
    run_frame(1'b0, 2000, cyc, nw, mw);
    n_cmp++;
    if (cyc !== 11 * NPIX) begin n_fail++; $display("FAIL done_cycles: got %0d required %0d", cyc, 11 * NPIX); end
    n_cmp++;
    if (nw !== NPIX) begin n_fail++; $display("FAIL done_nwin: got %0d required %0d", nw, NPIX); end
    n_cmp++;
    if (mw !== 1'b0) begin n_fail++; $display("FAIL memwrite_seen: got %b required 0", mw); end
    n_cmp++;
    if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b required 0", ifa.busy); end
    n_cmp++;
    if (got[5*16+7] !== 9'h010) begin n_fail++; $display("FAIL restart_centre: got %h required 010", got[5*16+7]); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_fail++; $display("FAIL done_single_pulse: got %0d extra busy/done cycles required 0", extra); end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifa.windowReady = 1'b1;
    ifb.windowReady = 1'b1;
    fill_img(1'b0);
    test_reset();
    test_all_ones(1'b0, 11 * NPIX);
    test_lone_pixel(1'b0, 11 * NPIX);
    test_backpressure();
    test_reset_mid_scan();
    test_done_and_restart();
    test_all_ones(1'b1, 13 * NPIX);
    test_lone_pixel(1'b1, 13 * NPIX);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
